// File: rtl/wide_stable_synchronizer_pkg.sv
// ----------------------------------------------------------------------------
// wide_sync_pkg
// Shared helpers for the wide stable synchronizer.
//   cnt_width(n) : bit width needed to hold the values 0..n (minimum 1).
// ----------------------------------------------------------------------------
package wide_sync_pkg;

    // Width of a counter that must reach n inclusive.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : wide_sync_pkg

// File: rtl/wide_stable_synchronizer_if.sv
// ----------------------------------------------------------------------------
// wide_stable_synchronizer_if
// Bus bundle between the asynchronous source side and the filtered,
// committed destination view.
//   in       : asynchronous input bus (driven by the source)
//   hold     : synchronous commit blocker
//   sync_out : raw last-stage synchronized value
//   out      : committed, filtered value
//   update   : one-cycle strobe on the cycle out changes
//   rise     : per-bit one-cycle strobe, committed 0->1
//   fall     : per-bit one-cycle strobe, committed 1->0
//
// Strobe semantics: there is no back-pressure. update/rise/fall are
// registered, exactly one cycle wide, and coincide with the first cycle on
// which out shows the new value; the consumer must take them that cycle.
// ----------------------------------------------------------------------------
interface wide_stable_synchronizer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in;
    logic             hold;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] out;
    logic             update;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Source / stimulus side.
    modport master (
        output in,
        output hold,
        input  sync_out,
        input  out,
        input  update,
        input  rise,
        input  fall
    );

    // Synchronizer side.
    modport slave (
        input  in,
        input  hold,
        output sync_out,
        output out,
        output update,
        output rise,
        output fall
    );
endinterface : wide_stable_synchronizer_if

// File: rtl/wide_stable_synchronizer_chain.sv
// ----------------------------------------------------------------------------
// multi_stage_sync_register
// Single-bit synchronizer chain of STAGES flops in series.
//   clk : destination clock
//   rst : asynchronous active-low reset; loads RESET_BIT into every stage
//   d   : asynchronous input bit
//   q   : last-stage (synchronized) bit
// ----------------------------------------------------------------------------
module multi_stage_sync_register #(
    parameter int   STAGES    = 2,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    // stage[0] is the metastability-exposed capture flop; later stages
    // give it time to resolve before anything downstream looks at it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= {STAGES{RESET_BIT}};
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule : multi_stage_sync_register

// File: rtl/wide_stable_synchronizer.sv
// ----------------------------------------------------------------------------
// wide_stable_synchronizer
// Bus-wide synchronizer followed by a stability filter. Each bit passes
// through its own STAGES-deep chain; the synchronized bus is committed to
// out only after it has held the same value long enough, so a skewed
// multi-bit change is never consumed half-updated.
//   clk : destination clock
//   rst : asynchronous active-low reset
//   bus : wide_stable_synchronizer_if.slave (in, hold -> sync_out, out,
//         update, rise, fall)
// Parameters: WIDTH (>=1), STAGES (>=2), STABLE_CYCLES (>=1), RESET_VALUE.
// ----------------------------------------------------------------------------
module wide_stable_synchronizer
    import wide_sync_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STAGES        = 2,
    parameter int               STABLE_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input logic                        clk,
    input logic                        rst,
    wide_stable_synchronizer_if.slave  bus
);

    localparam int             CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_THR = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] out_q;
    logic             update_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    logic             match;
    logic             commit;
    logic [CW-1:0]    cnt_d;

    // ------------------------------------------------------------------
    // Per-bit synchronizer chains
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        multi_stage_sync_register #(
            .STAGES    (STAGES),
            .RESET_BIT (RESET_VALUE[i])
        ) u_chain (
            .clk (clk),
            .rst (rst),
            .d   (bus.in[i]),
            .q   (sync_q[i])
        );
    end

    // ------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------
    // match compares the whole bus, so any intermediate value seen while
    // bits arrive with skew restarts the stability count.
    always_comb begin
        match  = (sync_q == prev_q);
        cnt_d  = cnt_q;
        if (!match) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // cnt counts matching cycles already seen; the current matching
        // cycle is the final one needed, hence the threshold of N-1.
        commit = match && (cnt_q >= CNT_THR) && (sync_q != out_q) && !bus.hold;
    end

    // cnt resets saturated so that the reset value is treated as already
    // stable and release does not produce a spurious commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= RESET_VALUE;
            cnt_q  <= CNT_MAX;
        end else begin
            prev_q <= sync_q;
            cnt_q  <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Commit register and edge strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= RESET_VALUE;
            update_q <= 1'b0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else if (commit) begin
            out_q    <= sync_q;
            update_q <= 1'b1;
            rise_q   <= sync_q & ~out_q;
            fall_q   <= ~sync_q & out_q;
        end else begin
            update_q <= 1'b0;
            rise_q   <= '0;
            fall_q   <= '0;
        end
    end

    assign bus.sync_out = sync_q;
    assign bus.out      = out_q;
    assign bus.update   = update_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;

endmodule : wide_stable_synchronizer

// File: tb/tb_wide_stable_synchronizer.sv
// ----------------------------------------------------------------------------
// tb_wide_stable_synchronizer
// Directed bench: default instance (8-bit, reset 0), a reset-value instance
// (8'hA5) and three parameter variants. Inputs change on the falling edge;
// outputs are sampled on the falling edge after each rising edge.
// ----------------------------------------------------------------------------
module tb_wide_stable_synchronizer;

    logic clk;
    logic rst;
    logic rst_r;

    int total = 0;
    int bad   = 0;

    // default instance
    wide_stable_synchronizer_if #(.WIDTH(8)) bus0 ();
    wide_stable_synchronizer #(.WIDTH(8), .STAGES(2), .STABLE_CYCLES(2),
        .RESET_VALUE(8'h00)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // reset-value instance
    wide_stable_synchronizer_if #(.WIDTH(8)) busr ();
    wide_stable_synchronizer #(.WIDTH(8), .STAGES(2), .STABLE_CYCLES(2),
        .RESET_VALUE(8'hA5)) dut_r (.clk(clk), .rst(rst_r), .bus(busr));

    // parameter variants
    wide_stable_synchronizer_if #(.WIDTH(16)) bus1 ();
    wide_stable_synchronizer #(.WIDTH(16), .STAGES(3), .STABLE_CYCLES(1),
        .RESET_VALUE(16'h00FF)) dut_p1 (.clk(clk), .rst(rst), .bus(bus1));

    wide_stable_synchronizer_if #(.WIDTH(1)) bus2 ();
    wide_stable_synchronizer #(.WIDTH(1), .STAGES(4), .STABLE_CYCLES(3),
        .RESET_VALUE(1'b0)) dut_p2 (.clk(clk), .rst(rst), .bus(bus2));

    wide_stable_synchronizer_if #(.WIDTH(16)) bus3 ();
    wide_stable_synchronizer #(.WIDTH(16), .STAGES(2), .STABLE_CYCLES(3),
        .RESET_VALUE(16'h0000)) dut_p3 (.clk(clk), .rst(rst), .bus(bus3));

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // one rising edge, then park on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        int ups;
        int ed;
        int ff_seen;
        int e1, e2, e3;
        logic [7:0]  cap_rise, cap_fall;
        logic [15:0] cap_rise1, cap_fall1;

        rst   = 1'b0;
        rst_r = 1'b0;
        bus0.in = 8'h00;   bus0.hold = 1'b0;
        busr.in = 8'h5A;   busr.hold = 1'b0;
        bus1.in = 16'h00FF; bus1.hold = 1'b0;
        bus2.in = 1'b0;    bus2.hold = 1'b0;
        bus3.in = 16'h0000; bus3.hold = 1'b0;

        // ---- reset with toggling input ----
        for (int k = 0; k < 4; k++) begin
            step();
            busr.in = ~busr.in;
        end
        check("rst_r_out",    32'(busr.out), 32'hA5);
        check("rst_r_sync",   32'(busr.sync_out), 32'hA5);
        check("rst_r_update", 32'(busr.update), 32'h0);
        check("rst_r_rise",   32'(busr.rise), 32'h0);
        check("rst_r_fall",   32'(busr.fall), 32'h0);
        check("rst0_out",     32'(bus0.out), 32'h00);
        check("rst0_update",  32'(bus0.update), 32'h0);

        busr.in = 8'hA5;
        rst   = 1'b1;
        rst_r = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (busr.update || bus0.update) seen++;
        end
        check("release_no_pulse", 32'(seen), 32'h0);
        check("release_r_out",    32'(busr.out), 32'hA5);

        // ---- single change 00 -> 81 ----
        bus0.in = 8'h81;
        step();  // edge 0
        check("single_sync_e0", 32'(bus0.sync_out), 32'h00);
        step();  // edge 1
        check("single_sync_e1", 32'(bus0.sync_out), 32'h81);
        step();
        step();  // edge 3
        check("single_out_e3",    32'(bus0.out), 32'h00);
        check("single_update_e3", 32'(bus0.update), 32'h0);
        step();  // edge 4
        check("single_out_e4",    32'(bus0.out), 32'h81);
        check("single_update_e4", 32'(bus0.update), 32'h1);
        check("single_rise_e4",   32'(bus0.rise), 32'h81);
        check("single_fall_e4",   32'(bus0.fall), 32'h00);
        step();  // edge 5
        check("single_update_e5", 32'(bus0.update), 32'h0);
        check("single_rise_e5",   32'(bus0.rise), 32'h00);
        check("single_out_e5",    32'(bus0.out), 32'h81);

        // ---- back to 00 ----
        bus0.in = 8'h00;
        for (int k = 0; k < 5; k++) step();  // edge 4
        check("back_update", 32'(bus0.update), 32'h1);
        check("back_fall",   32'(bus0.fall), 32'h81);
        check("back_out",    32'(bus0.out), 32'h00);
        for (int k = 0; k < 3; k++) step();

        // ---- glitch of 2 cycles is rejected ----
        bus0.in = 8'h01;
        step();
        step();
        bus0.in = 8'h00;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus0.update) seen++;
        end
        check("glitch_no_pulse", 32'(seen), 32'h0);
        check("glitch_out",      32'(bus0.out), 32'h00);

        // ---- 3-cycle pulse commits, then returns ----
        bus0.in = 8'h01;
        for (int k = 0; k < 3; k++) step();  // edges 0..2
        bus0.in = 8'h00;
        step();
        step();  // edge 4
        check("held3_update", 32'(bus0.update), 32'h1);
        check("held3_out",    32'(bus0.out), 32'h01);
        check("held3_rise",   32'(bus0.rise), 32'h01);
        for (int k = 0; k < 3; k++) step();  // edge 7
        check("held3_ret_update", 32'(bus0.update), 32'h1);
        check("held3_ret_fall",   32'(bus0.fall), 32'h01);
        check("held3_ret_out",    32'(bus0.out), 32'h00);
        for (int k = 0; k < 3; k++) step();

        // ---- skewed 0F -> FF -> F0 ----
        bus0.in = 8'h0F;
        for (int k = 0; k < 7; k++) step();
        check("skew_pre_out", 32'(bus0.out), 32'h0F);
        bus0.in = 8'hFF;
        step();  // edge 0
        bus0.in = 8'hF0;
        ups = 0; ed = -1; ff_seen = 0; cap_rise = '0; cap_fall = '0;
        for (int k = 1; k <= 10; k++) begin
            step();  // edge k
            if (bus0.out == 8'hFF) ff_seen++;
            if (bus0.update) begin
                ups++;
                ed = k;
                cap_rise = bus0.rise;
                cap_fall = bus0.fall;
            end
        end
        check("skew_updates", 32'(ups), 32'h1);
        check("skew_edge",    32'(ed), 32'h5);
        check("skew_ff_seen", 32'(ff_seen), 32'h0);
        check("skew_out",     32'(bus0.out), 32'hF0);
        check("skew_rise",    32'(cap_rise), 32'hF0);
        check("skew_fall",    32'(cap_fall), 32'h0F);

        // ---- hold ----
        bus0.in = 8'h00;
        for (int k = 0; k < 8; k++) step();
        check("hold_pre_out", 32'(bus0.out), 32'h00);
        bus0.hold = 1'b1;
        bus0.in   = 8'h3C;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus0.update) seen++;
        end
        check("hold_no_pulse", 32'(seen), 32'h0);
        check("hold_out",      32'(bus0.out), 32'h00);
        bus0.hold = 1'b0;
        step();
        check("hold_rel_update", 32'(bus0.update), 32'h1);
        check("hold_rel_out",    32'(bus0.out), 32'h3C);
        check("hold_rel_rise",   32'(bus0.rise), 32'h3C);
        check("hold_rel_fall",   32'(bus0.fall), 32'h00);
        step();
        check("hold_rel_update_next", 32'(bus0.update), 32'h0);

        // ---- parameter variants: commit edge = STAGES + STABLE_CYCLES ----
        bus1.in = 16'hBEEF;
        bus2.in = 1'b1;
        bus3.in = 16'h1234;
        e1 = -1; e2 = -1; e3 = -1; cap_rise1 = '0; cap_fall1 = '0;
        for (int e = 0; e < 12; e++) begin
            step();  // edge e
            if (bus1.update && e1 < 0) begin
                e1 = e;
                cap_rise1 = bus1.rise;
                cap_fall1 = bus1.fall;
            end
            if (bus2.update && e2 < 0) e2 = e;
            if (bus3.update && e3 < 0) e3 = e;
        end
        check("p1_edge", 32'(e1), 32'd4);
        check("p2_edge", 32'(e2), 32'd7);
        check("p3_edge", 32'(e3), 32'd5);
        check("p1_out",  32'(bus1.out), 32'hBEEF);
        check("p1_rise", 32'(cap_rise1), 32'hBE00);
        check("p1_fall", 32'(cap_fall1), 32'h0010);
        check("p2_out",  32'(bus2.out), 32'h1);
        check("p3_out",  32'(bus3.out), 32'h1234);

        // ---- async reset in the middle of filtering ----
        bus0.in = 8'h55;
        bus1.in = 16'h0000;
        bus2.in = 1'b0;
        bus3.in = 16'hFFFF;
        for (int k = 0; k < 3; k++) step();  // edges 0..2, nothing committed
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_p1_out",  32'(bus1.out), 32'h00FF);
        check("mid_rst_p1_sync", 32'(bus1.sync_out), 32'h00FF);
        check("mid_rst_p2_out",  32'(bus2.out), 32'h0);
        check("mid_rst_p3_out",  32'(bus3.out), 32'h0000);
        check("mid_rst_p3_sync", 32'(bus3.sync_out), 32'h0000);
        check("mid_rst_d0_out",  32'(bus0.out), 32'h00);
        check("mid_rst_upd",
              32'({bus0.update, bus1.update, bus2.update, bus3.update}), 32'h0);
        bus0.in = 8'h00;
        bus1.in = 16'h00FF;
        bus2.in = 1'b0;
        bus3.in = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus0.update || bus1.update || bus2.update || bus3.update) seen++;
        end
        check("mid_rst_no_pulse", 32'(seen), 32'h0);
        check("mid_rst_p1_final", 32'(bus1.out), 32'h00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wide_stable_synchronizer
